// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module : timer_pkg
// Brief  : Shared state encoding, value ranges and helpers for the
//          minute/second stopwatch and countdown timer blocks.
// Rev    : 1.0  initial release
// ============================================================================
package timer_pkg;

    localparam int MIN_W      = 2;
    localparam int SEC_W      = 6;
    localparam int MAX_SECOND = 59;
    localparam int MAX_MINUTE = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    function automatic logic [SEC_W-1:0] clamp_second(input logic [SEC_W-1:0] s);
        return (s > SEC_W'(MAX_SECOND)) ? SEC_W'(MAX_SECOND) : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pulse.sv
`default_nettype none
// ============================================================================
// Module : edge_pulse
// Brief  : Converts a button level into a single-cycle rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    // prev clears on reset, so a level held through reset release yields one press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = level & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module : countdown_timer
// Brief  : Loadable minute/second countdown with start/pause buttons and a
//          one-cycle expiry pulse.
// Rev    : 1.0  initial release
// ============================================================================
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [MIN_W-1:0] set_minute,
    input  logic [SEC_W-1:0] set_second,
    input  logic             start,
    input  logic             stop,
    output logic [MIN_W-1:0] minute,
    output logic [SEC_W-1:0] second,
    output logic             running,
    output logic             done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic start_pulse;
    logic stop_pulse;

    state_t           state_q,   state_d;
    logic [MIN_W-1:0] minute_q,  minute_d;
    logic [SEC_W-1:0] second_q,  second_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic             running_q, running_d;
    logic             done_q,    done_d;

    logic             count_zero;
    logic [MIN_W-1:0] minute_step;
    logic [SEC_W-1:0] second_step;
    logic             step_zero;

    edge_pulse u_start_edge (
        .clk   (clk),
        .reset (reset),
        .level (start),
        .pulse (start_pulse)
    );

    edge_pulse u_stop_edge (
        .clk   (clk),
        .reset (reset),
        .level (stop),
        .pulse (stop_pulse)
    );

    // Value the count would take on a step; borrow from minutes at :00
    always_comb begin
        count_zero = (minute_q == '0) && (second_q == '0);
        if (second_q != '0) begin
            second_step = second_q - SEC_W'(1);
            minute_step = minute_q;
        end else begin
            second_step = SEC_W'(MAX_SECOND);
            minute_step = minute_q - MIN_W'(1);
        end
        step_zero = (minute_step == '0) && (second_step == '0);
    end

    always_comb begin
        state_d  = state_q;
        minute_d = minute_q;
        second_d = second_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (load) begin
            minute_d = set_minute;
            second_d = clamp_second(set_second);
            state_d  = ST_IDLE;
            presc_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!stop_pulse && start_pulse && !count_zero) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (stop_pulse) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        if (!count_zero) begin
                            minute_d = minute_step;
                            second_d = second_step;
                            if (step_zero) begin
                                state_d = ST_EXPIRED;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!stop_pulse && start_pulse) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                default: begin
                    state_d = ST_EXPIRED;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            minute_q  <= '0;
            second_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            minute_q  <= minute_d;
            second_q  <= second_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign minute  = minute_q;
    assign second  = second_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module : tb_countdown_timer
// Brief  : Two timers (one step per clk, one step per 4 clks) on shared inputs,
//          compared each cycle against a total-seconds reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset, load, start, stop;
    logic [1:0] set_minute;
    logic [5:0] set_second;

    logic [1:0] min1, min4;
    logic [5:0] sec1, sec4;
    logic       run1, run4, done1, done4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .load(load), .set_minute(set_minute),
        .set_second(set_second), .start(start), .stop(stop),
        .minute(min1), .second(sec1), .running(run1), .done(done1)
    );

    countdown_timer #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .load(load), .set_minute(set_minute),
        .set_second(set_second), .start(start), .stop(stop),
        .minute(min4), .second(sec4), .running(run4), .done(done4)
    );

    // Reference: count kept as total seconds; mode 0 idle, 1 run, 2 pause, 3 expired
    int divs [2] = '{1, 4};
    int tot  [2];
    int mode [2];
    int ph   [2];
    bit dn   [2];
    bit prev_start, prev_stop;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            tot[i] = 0; mode[i] = 0; ph[i] = 0; dn[i] = 1'b0;
        end
        prev_start = 1'b0;
        prev_stop  = 1'b0;
    endfunction

    function automatic void model_edge();
        bit sta, stp;
        int s;
        sta = start & ~prev_start;
        stp = stop  & ~prev_stop;
        prev_start = start;
        prev_stop  = stop;
        for (int i = 0; i < 2; i++) begin
            dn[i] = 1'b0;
            if (load) begin
                s = (set_second > 59) ? 59 : int'(set_second);
                tot[i]  = int'(set_minute) * 60 + s;
                mode[i] = 0;
                ph[i]   = 0;
            end else if (mode[i] == 0) begin
                if (!stp && sta && tot[i] != 0) begin
                    mode[i] = 1; ph[i] = 0;
                end
            end else if (mode[i] == 1) begin
                if (stp) begin
                    mode[i] = 2;
                end else if (ph[i] == divs[i] - 1) begin
                    ph[i]  = 0;
                    tot[i] = tot[i] - 1;
                    if (tot[i] == 0) begin
                        mode[i] = 3; dn[i] = 1'b1;
                    end
                end else begin
                    ph[i] = ph[i] + 1;
                end
            end else if (mode[i] == 2) begin
                if (!stp && sta) begin
                    mode[i] = 1; ph[i] = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".div1.minute"},  32'(min1),  32'(tot[0] / 60));
        chk({tag, ".div1.second"},  32'(sec1),  32'(tot[0] % 60));
        chk({tag, ".div1.running"}, 32'(run1),  32'(mode[0] == 1));
        chk({tag, ".div1.done"},    32'(done1), 32'(dn[0]));
        chk({tag, ".div4.minute"},  32'(min4),  32'(tot[1] / 60));
        chk({tag, ".div4.second"},  32'(sec4),  32'(tot[1] % 60));
        chk({tag, ".div4.running"}, 32'(run4),  32'(mode[1] == 1));
        chk({tag, ".div4.done"},    32'(done4), 32'(dn[1]));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input int m, input int s);
        set_minute = 2'(m);
        set_second = 6'(s);
        load = 1'b1;
        step("load");
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b1; stop = 1'b0;
        set_minute = '0; set_second = '0;
        model_reset();
        #12;
        check_all("reset");

        // start held across reset release: one press, but 0:00 stays idle
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step("rst_start_held");
        chk("rst_start_held.running", 32'(run1), 32'd0);
        start = 1'b0;

        // 0:03 countdown to expiry, start held throughout
        do_load(0, 3);
        start = 1'b1;
        repeat (6) step("expire");
        chk("expire.div1.second", 32'(sec1), 32'd0);
        start = 1'b0;
        step("expire_rel");

        // borrow path, pause hold, resume
        do_load(1, 0);
        start = 1'b1;
        step("borrow_start");
        start = 1'b0;
        step("borrow_step");
        chk("borrow.div1.second", 32'(sec1), 32'd59);
        stop = 1'b1;
        step("pause");
        stop = 1'b0;
        repeat (10) step("pause_hold");
        chk("pause_hold.div1.second", 32'(sec1), 32'd59);
        start = 1'b1;
        repeat (2) step("resume");
        chk("resume.div1.second", 32'(sec1), 32'd58);
        start = 1'b0;

        // clamp and simultaneous start+stop in idle and pause
        do_load(2, 63);
        chk("clamp.minute", 32'(min1), 32'd2);
        chk("clamp.second", 32'(sec1), 32'd59);
        start = 1'b1; stop = 1'b1;
        step("both_idle");
        chk("both_idle.running", 32'(run1), 32'd0);
        start = 1'b0; stop = 1'b0;
        step("rel");
        start = 1'b1;
        repeat (3) step("run");
        start = 1'b0;
        stop = 1'b1;
        step("to_pause");
        stop = 1'b0;
        step("rel");
        start = 1'b1; stop = 1'b1;
        repeat (3) step("both_pause");
        start = 1'b0; stop = 1'b0;
        step("rel");

        // slow timer: 0:02 expires at N+8
        do_load(0, 2);
        start = 1'b1;
        repeat (10) step("div4");
        chk("div4.second", 32'(sec4), 32'd0);
        start = 1'b0;
        step("rel");

        // load wins over a simultaneous start press
        set_minute = 2'd1; set_second = 6'd5;
        load = 1'b1; start = 1'b1;
        step("load_start");
        chk("load_start.running", 32'(run4), 32'd0);
        load = 1'b0;
        repeat (3) step("load_start_hold");
        start = 1'b0;

        // asynchronous reset mid-count
        do_load(3, 10);
        start = 1'b1;
        repeat (3) step("pre_reset");
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) step("post_reset");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 9) == 0);
            load  = ($urandom_range(0, 19) == 0);
            set_minute = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            set_second = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 5))
                                                     : 6'($urandom_range(0, 63));
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Preset-and-count-down companion to the stopwatch: loads a minute/second value, counts down once per tick while running, and flags expiry with a one-cycle `done` pulse. Start/stop are raw button levels converted internally to single-press pulses. It drives the same minute/second display path as the stopwatch and uses the same value ranges (0:00–3:59).

## Interface
- `TICK_DIV`, default 1: clk cycles per count step (1 means one step per clk, as with the stopwatch); must be ≥1.
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `load`  in  1  level; when high, copy preset into count
- `set_minute`  in  2  preset minutes, 0–3
- `set_second`  in  6  preset seconds; values >59 clamp to 59
- `start`  in  1  button level; rising edge = start/resume
- `stop`  in  1  button level; rising edge = pause
- `minute`  out  2  current count minutes
- `second`  out  6  current count seconds, 0–59
- `running`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse on reaching 0:00 from RUN

## Operation
- Edge detect: per button, a previous-level register; press pulse = level & ~prev. A held button yields exactly one pulse. Prev registers reset to 0, so a button held high across reset release counts as one press.
- States: IDLE, RUN, PAUSE, EXPIRED.
  - IDLE → RUN on start pulse if count ≠ 0:00; otherwise stays in IDLE.
  - RUN → PAUSE on stop pulse; RUN → EXPIRED when a step takes the count to 0:00.
  - PAUSE → RUN on start pulse (count ≠ 0:00 is guaranteed).
  - EXPIRED: start/stop ignored; leaves only via load or reset.
- `load` (any state): count ← {set_minute, clamp(set_second)}, state → IDLE, prescaler cleared. Priority: reset > load > stop pulse > start pulse. A stop and a start pulse in the same cycle are treated as stop.
- Step (RUN and prescaler terminal): if second ≠ 0, second−1; else second ← 59, minute−1. 0:00 is never decremented (no wrap to 3:59).
- Prescaler: counts 0..TICK_DIV−1 only in RUN. It is cleared on entry to RUN and held in other states.
- `running` = (state == RUN), registered.

## Timing
- Reset values: minute=0, second=0, running=0, done=0, state IDLE, prescaler 0.
- All outputs are registered; no combinational input→output paths.
- Start pulse registered at edge N: running=1 after N. With TICK_DIV=1 the first step is at edge N+1; in general the first step is at edge N+TICK_DIV.
- Stop pulse at edge M: running=0 after M; no step at M. Count is frozen at its post-(M−1) value.
- Expiry: the edge that writes 0:00 also sets done=1 and running=0. done clears on the next edge.
- Load at edge L: count shows the preset after L. A start pulse in the same cycle is discarded.
- Reset asserted mid-count: outputs clear immediately (asynchronously); done is never emitted.

## Structure
- Package `timer_pkg`: state enum (IDLE, RUN, PAUSE, EXPIRED), `MAX_SECOND`=59, `MAX_MINUTE`=3, 2-/6-bit width constants; shared with the stopwatch.
- Sub-module `edge_pulse` (clk, reset, level → pulse), instantiated twice, for start and stop.
- Top holds the FSM, prescaler, count registers and clamp logic.

## Test plan
- Reset with start held high, release reset: one start pulse. With count 0:00 the block stays in IDLE and running stays 0.
- TICK_DIV=1: load 0:03, then start (held 5 cycles). Sequence 0:02, 0:01, 0:00 on consecutive edges. done=1 for exactly one cycle, coincident with 0:00; running=0 afterwards; holding start does not restart.
- Load 1:00, start, run 1 step: count 0:59 (borrow path). Stop: count holds 0:59 for 10 cycles. Start: 0:58 one edge later.
- Load set_second=63 with set_minute=2: count 2:59. Start and stop pressed on the same edge: state stays IDLE/PAUSE, running=0.
- TICK_DIV=4: load 0:02 and start at edge N. Steps at N+4 and N+8; done at N+8. Load asserted together with a start pulse: preset shown, running=0.
- Assert reset asynchronously between edges while running at 3:10: outputs go to 0 before the next edge, and no done pulse follows.
